ftw_display_driver: RTL and testbench

Sequential successor to the combinational FTW hex-display converter. It latches a DATA_W-bit tuning word on a load pulse and converts it to NUM_DIGITS seven-segment digits, in hex or in decimal. Decimal conversion uses a multi-cycle shift-add-3 (double-dabble) engine. It provides leading-zero blanking, overflow flagging and a busy/done handshake. It sits between the FTW register and the DE2 HEX display pins.

---
 rtl/ftw_display_driver_if.sv | 20 ++
 rtl/ftw_display_driver.sv | 123 ++++++++++++
 tb/tb_ftw_display_driver.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ftw_display_driver_if.sv
// Load/convert handshake and display outputs of the FTW display driver.
// master = the side issuing loads, slave = the converter.
interface ftw_display_driver_if #(
   parameter int DATA_W     = 32,
   parameter int NUM_DIGITS = 8
);
   logic                    load;
   logic [DATA_W-1:0]       data_in;
   logic                    mode_dec;
   logic                    busy;
   logic                    done;
   logic                    overflow;
   logic [4*NUM_DIGITS-1:0] digits_out;
   logic [7*NUM_DIGITS-1:0] seg_out;

   modport master (output load, data_in, mode_dec,
                   input  busy, done, overflow, digits_out, seg_out);
   modport slave  (input  load, data_in, mode_dec,
                   output busy, done, overflow, digits_out, seg_out);
endinterface

// File: rtl/ftw_display_driver.sv
// Latches a tuning word and renders it as hex or decimal seven-segment digits;
// decimal goes through a one-bit-per-cycle double-dabble engine.
module ftw_display_driver #(
   parameter int DATA_W      = 32,
   parameter int NUM_DIGITS  = 8,
   parameter bit BLANK_ZEROS = 1'b1
) (
   input logic               clk,
   input logic               reset,
   ftw_display_driver_if.slave bus
);
   localparam int BCD_DIGITS = (DATA_W * 3) / 10 + 1;
   localparam int HEX_DIGITS = (DATA_W + 3) / 4;
   localparam int MAX_SRC    = (BCD_DIGITS > HEX_DIGITS) ? BCD_DIGITS : HEX_DIGITS;
   localparam int SRC_DIGITS = (MAX_SRC > NUM_DIGITS) ? MAX_SRC : NUM_DIGITS;
   localparam int CNT_W      = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t                          state;
   logic [DATA_W-1:0]               word;
   logic                            is_dec;
   logic [4*BCD_DIGITS-1:0]         bcd;
   logic [4*BCD_DIGITS-1:0]         bcd_adj;
   logic [4*BCD_DIGITS+DATA_W-1:0]  shifted;
   logic [CNT_W-1:0]                cnt;
   logic [4*SRC_DIGITS-1:0]         src;
   logic [4*NUM_DIGITS-1:0]         digits_nx;
   logic [7*NUM_DIGITS-1:0]         seg_nx;
   logic                            ovf_nx;
   logic                            lead;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'h0: seg7 = 7'b1000000;
         4'h1: seg7 = 7'b1111001;
         4'h2: seg7 = 7'b0100100;
         4'h3: seg7 = 7'b0110000;
         4'h4: seg7 = 7'b0011001;
         4'h5: seg7 = 7'b0010010;
         4'h6: seg7 = 7'b0000010;
         4'h7: seg7 = 7'b1111000;
         4'h8: seg7 = 7'b0000000;
         4'h9: seg7 = 7'b0011000;
         4'hA: seg7 = 7'b0001000;
         4'hB: seg7 = 7'b0000011;
         4'hC: seg7 = 7'b1000110;
         4'hD: seg7 = 7'b0100001;
         4'hE: seg7 = 7'b0000110;
         default: seg7 = 7'b0001110;
      endcase
   endfunction

   always_comb begin
      bcd_adj = bcd;
      for (int j = 0; j < BCD_DIGITS; j++)
         if (bcd[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
      shifted = {bcd_adj, word} << 1;
   end

   // Source digits are padded with zeros so hex and BCD share one overflow/blank path.
   always_comb begin
      src = '0;
      if (is_dec) src[4*BCD_DIGITS-1:0] = bcd;
      else        src[DATA_W-1:0]       = word;
      ovf_nx = 1'b0;
      for (int i = NUM_DIGITS; i < SRC_DIGITS; i++)
         if (src[4*i +: 4] != 4'd0) ovf_nx = 1'b1;
      digits_nx = src[4*NUM_DIGITS-1:0];
      lead   = 1'b1;
      seg_nx = '1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (digits_nx[4*i +: 4] != 4'd0) lead = 1'b0;
         if (BLANK_ZEROS && !ovf_nx && lead && i != 0) seg_nx[7*i +: 7] = 7'h7f;
         else seg_nx[7*i +: 7] = seg7(digits_nx[4*i +: 4]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         word           <= '0;
         is_dec         <= 1'b0;
         bcd            <= '0;
         cnt            <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
         bus.overflow   <= 1'b0;
         bus.digits_out <= '0;
         bus.seg_out    <= '1;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: if (bus.load) begin
               word     <= bus.data_in;
               is_dec   <= bus.mode_dec;
               bus.busy <= 1'b1;
               if (bus.mode_dec) begin
                  bcd   <= '0;
                  cnt   <= CNT_W'(DATA_W);
                  state <= SHIFT;
               end else begin
                  state <= FINISH;
               end
            end
            SHIFT: begin
               {bcd, word} <= shifted;
               cnt         <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= FINISH;
            end
            FINISH: begin
               bus.digits_out <= digits_nx;
               bus.seg_out    <= seg_nx;
               bus.overflow   <= ovf_nx;
               bus.done       <= 1'b1;
               bus.busy       <= 1'b0;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ftw_display_driver.sv
// Scoreboard bench: two converters (blanking on/off) share stimulus; an
// arithmetic model predicts digits, segments, overflow and done timing.
module tb_ftw_display_driver;
   localparam int DW = 32;
   localparam int ND = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ftw_display_driver_if #(.DATA_W(DW), .NUM_DIGITS(ND)) bus ();
   ftw_display_driver_if #(.DATA_W(DW), .NUM_DIGITS(ND)) nb ();
   assign nb.load     = bus.load;
   assign nb.data_in  = bus.data_in;
   assign nb.mode_dec = bus.mode_dec;

   ftw_display_driver #(.DATA_W(DW), .NUM_DIGITS(ND), .BLANK_ZEROS(1'b1))
      dut (.clk(clk), .reset(reset), .bus(bus));
   ftw_display_driver #(.DATA_W(DW), .NUM_DIGITS(ND), .BLANK_ZEROS(1'b0))
      dut_nb (.clk(clk), .reset(reset), .bus(nb));

   typedef struct {
      int          due;
      logic [31:0] dig;
      logic [55:0] seg;
      logic [55:0] seg_nb;
      logic        ovf;
   } exp_t;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   exp_t        sb [$];
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          next_free = 0;
   int          act_k = 0;
   int          act_d = 0;
   bit          active = 1'b0;
   logic [31:0] held_dig = '0;
   logic [55:0] held_seg = '1;
   logic [55:0] held_nb = '1;
   logic        held_ovf = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] v, input bit dec, input int due);
      exp_t e;
      longint unsigned x, p;
      int d [8];
      int msd;
      x = {32'd0, v};
      p = 1;
      msd = 0;
      for (int i = 0; i < 8; i++) begin
         d[i] = dec ? int'((x / p) % 10) : int'((x >> (4 * i)) & 64'hF);
         p = p * 10;
         if (d[i] != 0) msd = i;
      end
      e.ovf = dec && (x >= 64'd100000000);
      e.dig = '0;
      for (int i = 0; i < 8; i++) begin
         e.dig[4*i +: 4]    = d[i][3:0];
         e.seg_nb[7*i +: 7] = seg_tab[d[i]];
         e.seg[7*i +: 7]    = (!e.ovf && i > msd) ? 7'h7f : seg_tab[d[i]];
      end
      e.due = due;
      return e;
   endfunction

   // Called at a negedge; load is sampled at the next rising edge (cyc+1).
   task automatic issue(input logic [31:0] v, input bit dec);
      int k;
      k = cyc + 1;
      bus.data_in  = v;
      bus.mode_dec = dec;
      bus.load     = 1'b1;
      if (k >= next_free) begin
         act_k     = k;
         act_d     = k + (dec ? DW + 1 : 1);
         next_free = act_d + 1;
         active    = 1'b1;
         sb.push_back(model(v, dec, act_d));
      end
      @(negedge clk);
      bus.load     = 1'b0;
      bus.data_in  = $urandom;
      bus.mode_dec = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb.delete();
      active    = 1'b0;
      next_free = 0;
      held_dig  = '0;
      held_seg  = '1;
      held_nb   = '1;
      held_ovf  = 1'b0;
      #1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_digits", bus.digits_out, 0);
      chk("rst_seg", bus.seg_out, 64'h00FF_FFFF_FFFF_FFFF);
      chk("rst_seg_nb", nb.seg_out, 64'h00FF_FFFF_FFFF_FFFF);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain_timeout: %0d conversions never completed", sb.size());
         sb.delete();
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!reset) begin
            if (bus.done) begin
               if (sb.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
               end else begin
                  e = sb.pop_front();
                  chk("done_cycle", 64'(cyc), 64'(e.due));
                  chk("digits", bus.digits_out, e.dig);
                  chk("seg", bus.seg_out, e.seg);
                  chk("seg_noblank", nb.seg_out, e.seg_nb);
                  chk("overflow", bus.overflow, e.ovf);
                  chk("done_noblank", nb.done, 1);
                  held_dig = e.dig;
                  held_seg = e.seg;
                  held_nb  = e.seg_nb;
                  held_ovf = e.ovf;
               end
            end else begin
               chk("hold_digits", bus.digits_out, held_dig);
               chk("hold_seg", bus.seg_out, held_seg);
               chk("hold_ovf", bus.overflow, held_ovf);
               if (sb.size() > 0 && cyc > sb[0].due) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL done_missing at cycle %0d: expected done at %0d", cyc, sb[0].due);
                  void'(sb.pop_front());
               end
            end
            chk("busy", bus.busy, 64'(active && cyc >= act_k && cyc < act_d));
         end
      end
   end

   initial begin : stim
      logic [31:0] v;
      bit          dec;
      bus.load     = 1'b0;
      bus.data_in  = '0;
      bus.mode_dec = 1'b0;
      repeat (2) @(negedge clk);
      do_reset();

      // reset mid-conversion, then a clean conversion
      issue(32'h0000_1234, 1'b1);
      repeat (5) @(negedge clk);
      do_reset();
      issue(32'h0000_1A2F, 1'b0);
      wait_idle();
      chk("hex_low_segs", bus.seg_out[27:0],
          {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110});
      chk("hex_high_blank", bus.seg_out[55:28], 64'h0FFF_FFFF);

      issue(32'hFFFF_FFFF, 1'b1);
      wait_idle();
      chk("dec_max_digits", bus.digits_out, 64'h9496_7295);
      chk("dec_max_digit7", bus.seg_out[55:49], 7'b0011000);
      chk("dec_max_ovf", bus.overflow, 1);

      issue(32'd0, 1'b1);
      wait_idle();
      chk("zero_blank", bus.seg_out, 64'h00FF_FFFF_FFFF_FFC0);

      // a second load while busy must be dropped
      issue(32'd12345678, 1'b1);
      repeat (4) @(negedge clk);
      issue(32'h0000_DEAD, 1'b0);
      wait_idle();
      chk("dec_12345678", bus.digits_out, 64'h1234_5678);

      issue(32'd87654321, 1'b1);
      repeat (9) @(negedge clk);
      do_reset();
      repeat (40) @(negedge clk);

      // back-to-back: next load lands in the done cycle
      issue(32'd99, 1'b1);
      while (cyc < act_d) @(negedge clk);
      issue(32'h0000_ABCD, 1'b0);
      wait_idle();
      chk("b2b_segs", bus.seg_out[27:0],
          {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001});

      repeat (60) begin
         case ($urandom_range(0, 3))
            0:       v = $urandom;
            1:       v = $urandom_range(0, 99999999);
            2:       v = $urandom_range(0, 999);
            default: v = 32'd0;
         endcase
         dec = 1'($urandom_range(0, 1));
         issue(v, dec);
         repeat ($urandom_range(0, 40)) @(negedge clk);
         if ($urandom_range(0, 15) == 0) do_reset();
      end
      wait_idle();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
